// File: rtl/ppl_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by ppl_hazard_ctrl and ppl_mdu_timer.
package ppl_hazard_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } hazStateT;

   localparam logic [4:0] REG_ZERO          = 5'd0;
   localparam int         DEFAULT_MDU_LAT   = 32;
   localparam int         DEFAULT_MDU_CNT_W = 6;

endpackage

// File: rtl/ppl_mdu_timer.sv
// MDU occupancy timer: loads the MDU latency on issue, then counts down to zero.
// The count saturates at zero and never wraps.
module ppl_mdu_timer
   import ppl_hazard_pkg::*;
#(
   parameter int LAT   = DEFAULT_MDU_LAT,
   parameter int CNT_W = DEFAULT_MDU_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic busy
);

   logic [CNT_W-1:0] cnt;

   // A fresh issue always wins over the countdown; otherwise drain towards zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CNT_W'(LAT);
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign busy = (cnt != '0);

endmodule

// File: rtl/ppl_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, MDU occupancy, fetch waits, branch redirects.
// Define PPL_HAZARD_PERF_EN to add the stallCycles/flushCount performance counter outputs.
module ppl_hazard_ctrl
   import ppl_hazard_pkg::*;
#(
   parameter int MDU_LAT   = DEFAULT_MDU_LAT,
   parameter int MDU_CNT_W = DEFAULT_MDU_CNT_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        imemReady,
   input  logic [4:0]  idRs,
   input  logic [4:0]  idRt,
   input  logic        idUsesRs,
   input  logic        idUsesRt,
   input  logic        idMduStart,
   input  logic        idUsesHiLo,
   input  logic [4:0]  exRd,
   input  logic        exMemRead,
   input  logic        branchTaken,
   input  logic [31:0] branchTarget,
`ifdef PPL_HAZARD_PERF_EN
   output logic [31:0] stallCycles,
   output logic [31:0] flushCount,
`endif
   output logic        pcContinue,
   output logic        flushD,
   output logic        flushE,
   output logic        pcRedirect,
   output logic [31:0] pcTarget,
   output logic        mduBusy
);

   hazStateT    state;
   hazStateT    nextState;
   logic [31:0] heldTarget;
   logic        latchTarget;
   logic        mduIssue;
   logic        timerBusy;
   logic        loadUse;
   logic        mduHaz;

   ppl_mdu_timer #(
      .LAT   (MDU_LAT),
      .CNT_W (MDU_CNT_W)
   ) mduTimer (
      .clk   (clk),
      .reset (reset),
      .load  (mduIssue),
      .busy  (timerBusy)
   );

   assign mduBusy = timerBusy & ~reset;

   // A load into r0 never creates a real dependency, so it is excluded from the compare.
   assign loadUse = exMemRead && (exRd != REG_ZERO) &&
                    ((idUsesRs && (idRs == exRd)) || (idUsesRt && (idRt == exRd)));
   assign mduHaz  = mduBusy && (idMduStart || idUsesHiLo);

   // Output priority: reset, then branch redirect, then fetch wait, then data hazards.
   always_comb begin
      pcContinue  = 1'b1;
      flushD      = 1'b0;
      flushE      = 1'b0;
      pcRedirect  = 1'b0;
      pcTarget    = '0;
      nextState   = state;
      latchTarget = 1'b0;
      mduIssue    = 1'b0;
      if (reset) begin
         pcContinue = 1'b0;
         flushD     = 1'b1;
         flushE     = 1'b1;
         nextState  = RUN;
      end else begin
         unique case (state)
            RUN: begin
               if (branchTaken && imemReady) begin
                  pcRedirect = 1'b1;
                  pcTarget   = branchTarget;
                  flushD     = 1'b1;
                  flushE     = 1'b1;
               end else if (branchTaken) begin
                  pcContinue  = 1'b0;
                  flushD      = 1'b1;
                  flushE      = 1'b1;
                  latchTarget = 1'b1;
                  nextState   = PEND;
               end else if (!imemReady || loadUse || mduHaz) begin
                  pcContinue = 1'b0;
                  flushE     = 1'b1;
               end else begin
                  mduIssue = idMduStart;
               end
            end
            PEND: begin
               flushD = 1'b1;
               flushE = 1'b1;
               if (imemReady) begin
                  pcRedirect = 1'b1;
                  pcTarget   = heldTarget;
                  nextState  = RUN;
               end else begin
                  pcContinue = 1'b0;
               end
            end
            default: begin
               nextState = RUN;
            end
         endcase
      end
   end

   // The held target survives fetch wait states so a redirect is never dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RUN;
         heldTarget <= '0;
      end else begin
         state <= nextState;
         if (latchTarget) begin
            heldTarget <= branchTarget;
         end
      end
   end

`ifdef PPL_HAZARD_PERF_EN
   // Free-running performance counters, wrapping naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         stallCycles <= '0;
         flushCount  <= '0;
      end else begin
         if (!pcContinue) begin
            stallCycles <= stallCycles + 32'd1;
         end
         if (pcRedirect) begin
            flushCount <= flushCount + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ppl_hazard_ctrl.sv
// Self-checking bench for ppl_hazard_ctrl: vector table for single-cycle decisions,
// directed sequences for load-use, fetch-stall redirect, MDU occupancy and reset during PEND.
module tb_ppl_hazard_ctrl;

   logic        clk;
   logic        reset;
   logic        imemReady;
   logic [4:0]  idRs;
   logic [4:0]  idRt;
   logic        idUsesRs;
   logic        idUsesRt;
   logic        idMduStart;
   logic        idUsesHiLo;
   logic [4:0]  exRd;
   logic        exMemRead;
   logic        branchTaken;
   logic [31:0] branchTarget;
   logic        pcContinue;
   logic        flushD;
   logic        flushE;
   logic        pcRedirect;
   logic [31:0] pcTarget;
   logic        mduBusy;
`ifdef PPL_HAZARD_PERF_EN
   logic [31:0] stallCycles;
   logic [31:0] flushCount;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic        imemReady;
      logic [4:0]  idRs;
      logic [4:0]  idRt;
      logic        idUsesRs;
      logic        idUsesRt;
      logic        idUsesHiLo;
      logic [4:0]  exRd;
      logic        exMemRead;
      logic        branchTaken;
      logic [31:0] branchTarget;
      logic        expPc;
      logic        expFlushD;
      logic        expFlushE;
      logic        expRedirect;
      logic [31:0] expTarget;
   } vecT;

   vecT vecs[12];

   ppl_hazard_ctrl #(
      .MDU_LAT   (4),
      .MDU_CNT_W (6)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .imemReady    (imemReady),
      .idRs         (idRs),
      .idRt         (idRt),
      .idUsesRs     (idUsesRs),
      .idUsesRt     (idUsesRt),
      .idMduStart   (idMduStart),
      .idUsesHiLo   (idUsesHiLo),
      .exRd         (exRd),
      .exMemRead    (exMemRead),
      .branchTaken  (branchTaken),
      .branchTarget (branchTarget),
`ifdef PPL_HAZARD_PERF_EN
      .stallCycles  (stallCycles),
      .flushCount   (flushCount),
`endif
      .pcContinue   (pcContinue),
      .flushD       (flushD),
      .flushE       (flushE),
      .pcRedirect   (pcRedirect),
      .pcTarget     (pcTarget),
      .mduBusy      (mduBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic checkCtl(input string nm, input logic pc, input logic fd, input logic fe,
                           input logic rd, input logic [31:0] tg);
      checkOutput({nm, ".pcContinue"}, 32'(pcContinue), 32'(pc));
      checkOutput({nm, ".flushD"},     32'(flushD),     32'(fd));
      checkOutput({nm, ".flushE"},     32'(flushE),     32'(fe));
      checkOutput({nm, ".pcRedirect"}, 32'(pcRedirect), 32'(rd));
      checkOutput({nm, ".pcTarget"},   pcTarget,        tg);
   endtask

   task automatic setIdle();
      imemReady    = 1'b1;
      idRs         = 5'd0;
      idRt         = 5'd0;
      idUsesRs     = 1'b0;
      idUsesRt     = 1'b0;
      idMduStart   = 1'b0;
      idUsesHiLo   = 1'b0;
      exRd         = 5'd0;
      exMemRead    = 1'b0;
      branchTaken  = 1'b0;
      branchTarget = 32'd0;
   endtask

   task automatic applyStimulus(input vecT v);
      imemReady    = v.imemReady;
      idRs         = v.idRs;
      idRt         = v.idRt;
      idUsesRs     = v.idUsesRs;
      idUsesRt     = v.idUsesRt;
      idMduStart   = 1'b0;
      idUsesHiLo   = v.idUsesHiLo;
      exRd         = v.exRd;
      exMemRead    = v.exMemRead;
      branchTaken  = v.branchTaken;
      branchTarget = v.branchTarget;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      setIdle();
      nextCycle();
      nextCycle();
      reset = 1'b0;
   endtask

   initial begin
      //          name         rdy rs     rt     uRs   uRt   hilo  exRd   mRd   br    target        pc fD fE rd target
      vecs[0]  = '{"idle",      1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0,         1, 0, 0, 0, 32'h0};
      vecs[1]  = '{"luRs",      1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 32'h0,         0, 0, 1, 0, 32'h0};
      vecs[2]  = '{"luRt",      1, 5'd3, 5'd9, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 32'h0,         0, 0, 1, 0, 32'h0};
      vecs[3]  = '{"luRsUnused",1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 32'h0,         1, 0, 0, 0, 32'h0};
      vecs[4]  = '{"luR0",      1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0,         1, 0, 0, 0, 32'h0};
      vecs[5]  = '{"noLoad",    1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 32'h0,         1, 0, 0, 0, 32'h0};
      vecs[6]  = '{"imemWait",  0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0,         0, 0, 1, 0, 32'h0};
      vecs[7]  = '{"imemWaitLu",0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 32'h0,         0, 0, 1, 0, 32'h0};
      vecs[8]  = '{"branch",    1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h8000_0040, 1, 1, 1, 1, 32'h8000_0040};
      vecs[9]  = '{"branchLu",  1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 32'h1234_5678, 1, 1, 1, 1, 32'h1234_5678};
      vecs[10] = '{"hiloIdle",  1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0,         1, 0, 0, 0, 32'h0};
      vecs[11] = '{"otherReg",  1, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 32'h0,         1, 0, 0, 0, 32'h0};

      reset = 1'b1;
      setIdle();
      nextCycle();
      nextCycle();
      @(negedge clk);
      checkCtl("resetHeld", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("resetHeld.mduBusy", 32'(mduBusy), 32'd0);
      nextCycle();
      reset = 1'b0;
      @(negedge clk);
      checkCtl("afterReset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("afterReset.mduBusy", 32'(mduBusy), 32'd0);

      for (int i = 0; i < 12; i++) begin
         nextCycle();
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkCtl(vecs[i].name, vecs[i].expPc, vecs[i].expFlushD, vecs[i].expFlushE,
                  vecs[i].expRedirect, vecs[i].expTarget);
      end

      // Load-use stalls once; the load then leaves EX and a bubble takes its place.
      nextCycle();
      setIdle();
      exMemRead = 1'b1; exRd = 5'd8; idRs = 5'd8; idUsesRs = 1'b1;
      @(negedge clk);
      checkCtl("luSeq0", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      nextCycle();
      exMemRead = 1'b0; exRd = 5'd0;
      @(negedge clk);
      checkCtl("luSeq1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

      // Branch arriving during a fetch wait is held in PEND until imemReady.
      nextCycle();
      setIdle();
      imemReady = 1'b0; branchTaken = 1'b1; branchTarget = 32'h8000_0100;
      @(negedge clk);
      checkCtl("pendEnter", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      for (int k = 0; k < 2; k++) begin
         nextCycle();
         branchTaken = 1'b1; branchTarget = 32'hDEAD_BEE0;
         @(negedge clk);
         checkCtl($sformatf("pendWait%0d", k), 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      end
      nextCycle();
      imemReady = 1'b1; branchTaken = 1'b0;
      @(negedge clk);
      checkCtl("pendRedirect", 1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0100);
      nextCycle();
      setIdle();
      @(negedge clk);
      checkCtl("pendBackRun", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

      // MDU: mult issues, then mfhi waits out the 4-cycle occupancy.
      nextCycle();
      setIdle();
      idMduStart = 1'b1;
      @(negedge clk);
      checkCtl("mduIssue", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("mduIssue.mduBusy", 32'(mduBusy), 32'd0);
      nextCycle();
      idMduStart = 1'b0; idUsesHiLo = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput($sformatf("mduStall%0d.mduBusy", k), 32'(mduBusy), 32'd1);
         checkCtl($sformatf("mduStall%0d", k), 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
         nextCycle();
      end
      @(negedge clk);
      checkOutput("mduDone.mduBusy", 32'(mduBusy), 32'd0);
      checkCtl("mduDone", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

      // Wrong-path mult flushed by a branch must not start the timer.
      nextCycle();
      setIdle();
      idMduStart = 1'b1; branchTaken = 1'b1; branchTarget = 32'h0000_0200;
      @(negedge clk);
      checkCtl("mduBranch", 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
      nextCycle();
      setIdle();
      idUsesHiLo = 1'b1;
      @(negedge clk);
      checkOutput("mduBranchAfter.mduBusy", 32'(mduBusy), 32'd0);
      checkOutput("mduBranchAfter.pcContinue", 32'(pcContinue), 32'd1);

      // Reset while PEND discards the held redirect.
      nextCycle();
      setIdle();
      imemReady = 1'b0; branchTaken = 1'b1; branchTarget = 32'h8000_0300;
      @(negedge clk);
      checkCtl("rstPendEnter", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      nextCycle();
      setIdle();
      reset = 1'b1;
      @(negedge clk);
      checkCtl("rstPendHeld", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      nextCycle();
      reset = 1'b0;
      @(negedge clk);
      checkCtl("rstPendAfter", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef PPL_HAZARD_PERF_EN
      checkOutput("rstPendAfter.stallCycles", stallCycles, 32'd0);
      checkOutput("rstPendAfter.flushCount",  flushCount,  32'd0);
      nextCycle();
      imemReady = 1'b0;
      @(negedge clk);
      nextCycle();
      imemReady = 1'b1; branchTaken = 1'b1; branchTarget = 32'h40;
      @(negedge clk);
      checkOutput("perf.stallCycles", stallCycles, 32'd1);
      nextCycle();
      setIdle();
      @(negedge clk);
      checkOutput("perf.flushCount", flushCount, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
